// File: rtl/fp_mul_sched.sv
// Round-robin scheduler that shares one fixed-latency pipelined FP64 multiplier
// among N_REQ requesters, tracking requester IDs through a latency-matched tag pipe.
module fp_mul_sched #(
    parameter int N_REQ = 4,
    parameter int LAT   = 3,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*64-1:0]   req_a,
    input  logic [N_REQ*64-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  fpu_valid,
    output logic [63:0]           fpu_a,
    output logic [63:0]           fpu_b,
    input  logic [63:0]           fpu_result,
    input  logic                  fpu_result_valid,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [63:0]           rsp_data,
    input  logic                  drain,
    output logic                  busy,
    output logic                  err,
    input  logic                  err_clr
);

    typedef enum logic {
        ARB   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [ID_W-1:0]  rr_ptr_reg;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic             handshake;
    logic [63:0]      sel_a;
    logic [63:0]      sel_b;
    logic [N_REQ-1:0] grant_onehot;
    logic [N_REQ-1:0] rsp_onehot;

    // Stage 0 lines up with fpu_valid; stage LAT lines up with the returning result.
    logic [LAT:0]     tag_valid_reg;
    logic [ID_W-1:0]  tag_id_reg [LAT+1];

    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_ptr_reg) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
        assign grant_onehot[gi] = found && (winner == ID_W'(gi));
        assign rsp_onehot[gi]   = (tag_id_reg[LAT] == ID_W'(gi));
    end

    assign sel_a = req_a[64*int'(winner) +: 64];
    assign sel_b = req_b[64*int'(winner) +: 64];

    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        case (state_reg)
            ARB: begin
                if (drain) begin
                    state_next = DRAIN;
                end else begin
                    req_ready = grant_onehot;
                end
            end
            DRAIN: begin
                if (!drain && !busy) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    assign handshake = |(req_ready & req_valid);
    assign busy      = fpu_valid | (|tag_valid_reg) | (|rsp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ARB;
            rr_ptr_reg <= ID_W'(N_REQ - 1);
            fpu_valid  <= 1'b0;
            fpu_a      <= '0;
            fpu_b      <= '0;
        end else begin
            state_reg <= state_next;
            fpu_valid <= handshake;
            if (handshake) begin
                rr_ptr_reg <= winner;
                fpu_a      <= sel_a;
                fpu_b      <= sel_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_reg <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_id_reg[k] <= '0;
            end
        end else begin
            tag_valid_reg <= {tag_valid_reg[LAT-1:0], handshake};
            tag_id_reg[0] <= handshake ? winner : '0;
            for (int k = 1; k <= LAT; k++) begin
                tag_id_reg[k] <= tag_id_reg[k-1];
            end
        end
    end

    // A result without a tag, or a tag without a result, is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (fpu_result_valid && tag_valid_reg[LAT]) begin
                rsp_valid <= rsp_onehot;
                rsp_id    <= tag_id_reg[LAT];
                rsp_data  <= fpu_result;
            end
            if (fpu_result_valid != tag_valid_reg[LAT]) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fp_mul_sched.md
Name: fp_mul_sched

Overview:
- Round-robin scheduler sharing one fixed-latency pipelined double-precision multiplier (64-bit packed sign/exponent/mantissa) among N_REQ requesters in the fetal-ECG datapath.
- Arbitrates one operation per cycle and drives the shared unit.
- Tracks each in-flight requester ID through a latency-matched tag pipeline and routes results back.
- Supports a drain mode for reconfiguration and flags latency mismatches from the unit.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- LAT, 3, fixed multiplier latency in cycles from fpu_valid to fpu_result_valid (1..32).
- ID_W, 2, requester ID width, equal to clog2(N_REQ).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester operation request
- req_a  in  N_REQ*64  operand A, requester i at bits [64i+63:64i]
- req_b  in  N_REQ*64  operand B, same packing as req_a
- req_ready  out  N_REQ  one-hot grant; handshake when req_valid[i]&req_ready[i]
- fpu_valid  out  1  issue strobe to the shared multiplier
- fpu_a  out  64  operand A to the multiplier
- fpu_b  out  64  operand B to the multiplier
- fpu_result  in  64  multiplier result
- fpu_result_valid  in  1  multiplier result strobe
- rsp_valid  out  N_REQ  one-hot result delivery; no backpressure
- rsp_id  out  ID_W  ID of the delivered result
- rsp_data  out  64  delivered result
- drain  in  1  level request to stop granting and empty the pipeline
- busy  out  1  any operation in flight
- err  out  1  sticky latency-mismatch flag
- err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (async, rst=1): state=ARB; rr_ptr=N_REQ-1; fpu_valid=0; fpu_a=fpu_b=0; rsp_valid=0; rsp_id=0; rsp_data=0; tag pipeline cleared; err=0; busy=0.
- Reset mid-operation aborts everything in flight. Results returning after reset deassertion are unexpected and set err.
- States:
  - ARB: grants allowed. If drain=1, go to DRAIN next cycle. No grant is made in the cycle drain is sampled high.
  - DRAIN: req_ready=0. Return to ARB when drain=0 and busy=0.
- Arbitration (ARB, drain=0), combinational:
  - Winner is the first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, … modulo N_REQ.
  - req_ready = onehot(winner); all zeros if no request. At most one bit set.
- On handshake:
  - rr_ptr <= winner.
  - Next cycle: fpu_valid=1, fpu_a/fpu_b = winner's operands, tag stage0 = {1, winner}.
  - With no handshake: fpu_valid=0 and fpu_a/fpu_b hold their values.
- Tag pipeline:
  - LAT-deep shift register of {valid, ID}, advancing every cycle.
  - Entry issued with fpu_valid reaches the output stage exactly LAT cycles later, aligned with the expected fpu_result_valid.
- Result routing:
  - When fpu_result_valid=1 and the output tag is valid: next cycle rsp_valid=onehot(tag ID), rsp_id=tag ID, rsp_data=fpu_result.
  - Otherwise rsp_valid=0; rsp_id and rsp_data hold.
- Latency: handshake to rsp_valid is LAT+2 cycles. Throughput is one op per cycle.
- Errors:
  - fpu_result_valid=1 with output tag invalid: err<=1, result dropped.
  - Output tag valid with fpu_result_valid=0: err<=1, tag dropped, no rsp.
  - err_clr=1 clears err. If a new error occurs in the same cycle, set wins.
- busy = fpu_valid | any tag valid | (rsp_valid!=0).
- Fairness: a continuously requesting requester waits at most N_REQ-1 grants.
- Back-to-back requests from the same requester are allowed, subject to rotation.
- drain asserted while req_valid is held: requests stay pending, untouched; they are granted after return to ARB.
- Widths: all index arithmetic is modulo N_REQ. rsp_id is zero-extended to ID_W.

Test Plan:
- N_REQ=4, LAT=3. Req 2 only, a=0x4000000000000000, b=0x4008000000000000 → req_ready=0100. fpu_valid 1 cycle later with those operands. Model returns 0x4018000000000000. rsp_valid=0100, rsp_id=2, rsp_data=0x4018000000000000 at handshake+5.
- All 4 requesting continuously from reset → grant order 0,1,2,3,0,… one per cycle. rsp_id sequence is 0,1,2,3,… with no gaps.
- Requests from 1 and 3, rr_ptr=1 → 3 granted first, then 1. Drop req 3 after its grant → 1 is granted every cycle.
- drain=1 while 4 ops in flight → req_ready=0 immediately. All 4 rsp delivered, busy falls. drain=0 → ARB resumes with the pending req 0 granted the next cycle.
- Model delays one result to LAT+1 → err=1 and that rsp is missing. err_clr pulse → err=0. Correct traffic afterwards leaves err=0.
- Assert rst with 3 ops in flight → all outputs at reset values asynchronously, busy=0. Late fpu_result_valid after release → err=1, no rsp_valid.
